// File: rtl/fft_frame_sequencer_if.sv
// Stream-side bundle of the FFT frame sequencer: config and sample AXI-Stream channels.
interface fft_frame_sequencer_if;
  logic [15:0] cfg_tdata_out;
  logic        cfg_tvalid_out;
  logic        cfg_tready_in;
  logic [31:0] fft_tdata_out;
  logic        fft_tvalid_out;
  logic        fft_tlast_out;
  logic        fft_tready_in;

  // Sequencer side drives data/valid/last and receives ready.
  modport master (
    output cfg_tdata_out, cfg_tvalid_out,
    input  cfg_tready_in,
    output fft_tdata_out, fft_tvalid_out, fft_tlast_out,
    input  fft_tready_in
  );

  // FFT core side.
  modport slave (
    input  cfg_tdata_out, cfg_tvalid_out,
    output cfg_tready_in,
    input  fft_tdata_out, fft_tvalid_out, fft_tlast_out,
    output fft_tready_in
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Streams a recorded sample buffer into an FFT core frame by frame:
// one config beat, then FRAME_LEN beats per frame (zero padded past the
// recorded length), waiting for each frame's output before the next.
module fft_frame_sequencer #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] CFG_WORD  = 16'h0001
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] rec_len_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [7:0]        mem_data_in,
  fft_frame_sequencer_if.master axis,
  input  logic              frame_done_in,
  output logic [ADDR_W-1:0] frame_idx_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned S_W   = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE, CFG, FETCH, LOAD, SEND, WAIT_OUT, DONE
  } state_t;

  state_t            state_q;
  logic [S_W-1:0]    s_q;
  logic [IDX_W-1:0]  base_q;
  logic [IDX_W-1:0]  len_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] frame_idx_q;
  logic [15:0]       cfg_tdata_q;
  logic              cfg_tvalid_q;
  logic [31:0]       fft_tdata_q;
  logic              fft_tvalid_q;
  logic              fft_tlast_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [IDX_W-1:0]  g_c;
  logic [IDX_W-1:0]  next_base_c;
  logic              last_beat_c;

  // Global sample index and next-frame base, one bit wider than the address so nothing wraps.
  always_comb begin
    g_c         = base_q + IDX_W'(s_q);
    next_base_c = base_q + IDX_W'(FRAME_LEN);
    last_beat_c = (s_q == S_W'(FRAME_LEN - 1));
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      s_q          <= '0;
      base_q       <= '0;
      len_q        <= '0;
      mem_addr_q   <= '0;
      frame_idx_q  <= '0;
      cfg_tdata_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      fft_tdata_q  <= '0;
      fft_tvalid_q <= 1'b0;
      fft_tlast_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            if (rec_len_in == '0) begin
              err_q <= 1'b1;
            end else begin
              len_q        <= IDX_W'(rec_len_in);
              s_q          <= '0;
              base_q       <= '0;
              frame_idx_q  <= '0;
              busy_q       <= 1'b1;
              cfg_tvalid_q <= 1'b1;
              cfg_tdata_q  <= CFG_WORD;
              state_q      <= CFG;
            end
          end
        end
        CFG: begin
          if (axis.cfg_tready_in) begin
            cfg_tvalid_q <= 1'b0;
            cfg_tdata_q  <= '0;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          if (g_c < len_q) begin
            mem_addr_q <= g_c[ADDR_W-1:0];
            state_q    <= LOAD;
          end else begin
            fft_tdata_q  <= '0;
            fft_tvalid_q <= 1'b1;
            fft_tlast_q  <= last_beat_c;
            state_q      <= SEND;
          end
        end
        LOAD: begin
          fft_tdata_q  <= {16'h0000, mem_data_in, 8'h00};
          fft_tvalid_q <= 1'b1;
          fft_tlast_q  <= last_beat_c;
          state_q      <= SEND;
        end
        SEND: begin
          if (axis.fft_tready_in) begin
            fft_tvalid_q <= 1'b0;
            fft_tlast_q  <= 1'b0;
            if (last_beat_c) begin
              s_q     <= '0;
              state_q <= WAIT_OUT;
            end else begin
              s_q     <= s_q + S_W'(1);
              state_q <= FETCH;
            end
          end
        end
        WAIT_OUT: begin
          if (frame_done_in) begin
            if (next_base_c >= len_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              frame_idx_q <= frame_idx_q + ADDR_W'(1);
              base_q      <= next_base_c;
              state_q     <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_out        = mem_addr_q;
  assign frame_idx_out       = frame_idx_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign err_out             = err_q;
  assign axis.cfg_tdata_out  = cfg_tdata_q;
  assign axis.cfg_tvalid_out = cfg_tvalid_q;
  assign axis.fft_tdata_out  = fft_tdata_q;
  assign axis.fft_tvalid_out = fft_tvalid_q;
  assign axis.fft_tlast_out  = fft_tlast_q;

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 1024, samples per FFT frame (power of two, ≥4).
REQ-002 Parameter ADDR_W, default 16, sample-memory address width.
REQ-003 Parameter CFG_WORD, default 16'h0001, FFT config word (forward transform).
REQ-004 clk_in  input  1  single system clock; all logic on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 start_in  input  1  one-cycle pulse launching a sequence.
REQ-007 rec_len_in  input  ADDR_W  number of recorded samples; sampled on accepted start.
REQ-008 mem_addr_out  output  ADDR_W  sample-memory read address.
REQ-009 mem_data_in  input  8  signed sample, valid exactly one cycle after mem_addr_out changes.
REQ-010 cfg_tdata_out  output  16  FFT config data.
REQ-011 cfg_tvalid_out / cfg_tready_in  output/input  1  config AXI-Stream handshake.
REQ-012 fft_tdata_out  output  32  FFT input sample: [31:16] imaginary, [15:0] real.
REQ-013 fft_tvalid_out / fft_tlast_out / fft_tready_in  output/output/input  1  FFT input AXI-Stream.
REQ-014 frame_done_in  input  1  pulse when FFT output stream transfers its tlast beat.
REQ-015 frame_idx_out  output  ADDR_W  index of frame currently being sent.
REQ-016 busy_out  output  1  high from accepted start until done.
REQ-017 done_out  output  1  one-cycle completion pulse.
REQ-018 err_out  output  1  one-cycle pulse on start with rec_len_in == 0.

Function
REQ-019 States: IDLE, CFG, FETCH, LOAD, SEND, WAIT_OUT, DONE.
REQ-020 IDLE: start_in with rec_len_in>0 latches length, clears sample counter s and frame_idx_out, goes to CFG; rec_len_in==0 pulses err_out, stays IDLE.
REQ-021 start_in outside IDLE is ignored.
REQ-022 CFG: cfg_tvalid_out=1, cfg_tdata_out=CFG_WORD, held stable until cfg_tready_in; transfer cycle -> FETCH.
REQ-023 Global sample index g = frame_idx_out*FRAME_LEN + s; s counts 0..FRAME_LEN-1.
REQ-024 FETCH: if g < latched length, mem_addr_out=g -> LOAD; otherwise -> SEND with fft_tdata_out=0 (zero pad, no memory read).
REQ-025 LOAD: fft_tdata_out = {16'h0000, mem_data_in, 8'h00} -> SEND.
REQ-026 SEND: fft_tvalid_out=1; tdata/tlast stable until fft_tready_in; fft_tlast_out=1 only when s==FRAME_LEN-1.
REQ-027 On SEND transfer: non-last beat increments s -> FETCH; last beat clears s -> WAIT_OUT.
REQ-028 Max throughput: one beat per 3 cycles (memory samples), 2 cycles (padding).
REQ-029 WAIT_OUT: on frame_done_in, if (frame_idx_out+1)*FRAME_LEN ≥ latched length -> DONE, else frame_idx_out+1 -> FETCH.
REQ-030 frame_done_in outside WAIT_OUT is ignored.
REQ-031 DONE: done_out=1 for one cycle, busy_out falls next cycle, -> IDLE.
REQ-032 Frames sent = ceil(length/FRAME_LEN); total beats = frames*FRAME_LEN exactly.
REQ-033 Config is sent once per sequence, never between frames.
REQ-034 Index arithmetic is ADDR_W+1 bits wide; no wrap on length = 2^ADDR_W-1.

Reset
REQ-035 rst_in low at a clock edge forces IDLE and all outputs to 0 (mem_addr_out, frame_idx_out, tdata included) on that edge, from any state, including mid-SEND with tvalid high.
REQ-036 After rst_in returns high, no output changes until a new start_in.

Verification
REQ-037 FRAME_LEN=8, length 8, tready always 1, frame_done_in 5 cycles after tlast -> one config beat 16'h0001, 8 beats real={mem[i],8'h00}, tlast on beat 8, done_out once.
REQ-038 length 10, FRAME_LEN=8 -> frames 0 and 1; frame 1 beats 0-1 from mem[8..9], beats 2-7 tdata=0; tlast twice; frame_idx_out 0 then 1.
REQ-039 Random tready stalls (50%) -> tdata/tlast never change while tvalid && !tready; beat count still 16 for length 10.
REQ-040 start_in with rec_len_in=0 -> err_out one cycle, busy_out stays 0, no stream beats; second start_in during busy -> ignored.
REQ-041 rst_in low during frame 0 beat 3 -> next edge all outputs 0; subsequent start produces full sequence from beat 0 with config resent.
REQ-042 Early frame_done_in while in SEND -> ignored; sequence waits for frame_done_in in WAIT_OUT before frame 1.
